mmio_console: RTL
=================

Name: mmio_console

Overview:
- Memory-mapped console/halt responder on the single-cycle MIPS data port; the device end of the CPU's store/load traffic (memwrite, dataadr, writedata, readdata).
- CPU stores to TXDATA push bytes into a FIFO, which drains over a valid/ready byte stream to a bench or UART.
- STATUS, HALT and TXCOUNT registers let programs poll the console and end a run with a code.
- Sits beside dmem in top; top muxes readdata from this block when hit=1.

Parameters:
- ADDR_BASE, 32'hFFFF_FF00, base address of the 16-byte register window (bits [3:0] must be 0).
- DEPTH, 8, FIFO depth in bytes (power of two, >=2).
- CNT_W, 4, FIFO occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  CPU store strobe, valid for the whole cycle.
- dataadr  in  32  CPU data address.
- writedata  in  32  CPU store data.
- readdata  out  32  combinational register read data.
- hit  out  1  combinational; 1 when dataadr[31:4]==ADDR_BASE[31:4].
- tx_data  out  8  byte at the FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts the byte when tx_valid&tx_ready at a rising edge.
- halt  out  1  sticky halt flag.
- halt_code  out  32  value written to HALT.

Behaviour:
- Register map (offset = dataadr[3:0]; word accesses only, dataadr[1:0] ignored):
  - 0x0 TXDATA: write pushes writedata[7:0]; reads 0.
  - 0x4 STATUS: read {16'b0, count[7:0], 5'b0, ovf, full, empty}. A write with writedata[2]=1 clears ovf.
  - 0x8 HALT: write sets halt=1 and halt_code=writedata. Reads halt_code.
  - 0xC TXCOUNT: read-only 32-bit count of bytes handed off (tx_valid&tx_ready). Wraps 0xFFFFFFFF->0. Writes ignored.
- Stores are accepted when memwrite&hit at the rising edge. When hit=0, all state is unchanged.
- readdata is combinational from current state, not from same-cycle writes. It is 0 when hit=0.
- Reset (reset=0, asynchronous):
  - FIFO empty, count=0, ovf=0.
  - tx_valid=0, tx_data=0.
  - halt=0, halt_code=0, TXCOUNT=0.
  - Pointers return to 0.
  - Reset mid-stream discards queued bytes. No tx handshake completes on a reset-release edge.
- FIFO is a circular buffer with rd_ptr/wr_ptr (log2 DEPTH bits, wrap at DEPTH) and a count.
  - empty = count==0; full = count==DEPTH.
  - tx_data = mem[rd_ptr] (0 when empty); tx_valid = !empty.
- Latency: a byte pushed at edge N appears on tx_valid/tx_data after edge N, i.e. first visible in cycle N+1.
- Pop: tx_valid&tx_ready at an edge advances rd_ptr, decrements count and increments TXCOUNT.
- Push and pop in the same edge:
  - Count is unchanged.
  - A push is accepted even when full, because the pop frees the slot.
  - When count==1, the new byte becomes head next cycle.
- Push while full without a simultaneous pop: byte dropped, ovf set (sticky), pointers and count unchanged.
- tx_data/tx_valid must stay stable while tx_valid=1 and tx_ready=0.
- HALT:
  - The first write sets halt and latches the code.
  - Later HALT writes are ignored until reset.
  - halt does not stop the FIFO draining or further TXDATA pushes.
- Simultaneous STATUS ovf-clear and an overflowing push: the push-overflow wins and ovf=1.

Test Plan:
- Reset held low 2 cycles, then released -> readdata at 0xFFFFFF04 = 0x00000001, tx_valid=0, halt=0, TXCOUNT reads 0.
- Store 0x41 to 0xFFFFFF00 with tx_ready=0 -> next cycle tx_valid=1, tx_data=0x41, STATUS=0x00000100. Raise tx_ready for 1 cycle -> tx_valid=0, TXCOUNT=1.
- Store 9 bytes 0x01..0x09 with tx_ready=0 -> STATUS=0x00000806 (count 8, ovf, full). Drain -> sink receives 0x01..0x08 in order. Byte 0x09 never appears; TXCOUNT=8.
- FIFO full, tx_ready=1 and a store of 0xAA in the same cycle -> count stays 8. 0xAA is delivered 8th after the existing bytes. ovf unchanged.
- Store 0xDEAD0001 then 0x12345678 to 0xFFFFFF08 -> halt=1, halt_code=0xDEAD0001 (second write ignored). Store to 0x00000008 -> no effect, hit=0, readdata=0.
- Queue 3 bytes, pull reset low mid-cycle (asynchronously) -> tx_valid drops immediately. After release STATUS=0x00000001 and no stale byte appears.

Source files
------------

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console / halt responder on the CPU data port.
// CPU stores to TXDATA queue bytes into a small FIFO that drains over a
// valid/ready byte stream. STATUS, HALT and TXCOUNT let software poll the
// console and end a run with a code.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   memwrite   CPU store strobe
//   dataadr    CPU data address (word accesses, [1:0] ignored)
//   writedata  CPU store data
//   readdata   combinational register read data (0 when hit=0)
//   hit        dataadr falls inside the 16-byte register window
//   tx_data    byte at FIFO head (0 when empty)
//   tx_valid   FIFO non-empty
//   tx_ready   sink accepts head byte on tx_valid&tx_ready
//   halt       sticky halt flag
//   halt_code  value latched by the first HALT write
module mmio_console #(
  parameter logic [31:0] ADDR_BASE = 32'hFFFF_FF00,
  parameter int          DEPTH     = 8,
  parameter int          CNT_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_HALT    = 2'd2;
  localparam logic [1:0] OFF_TXCOUNT = 2'd3;

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [31:0]      txcount;

  logic [1:0] off;
  logic       we, push, pop, empty, full, push_ok;
  logic [7:0] cnt8;
  logic       unused_adr;

  // Byte-lane bits carry no meaning for word-only registers.
  assign unused_adr = ^dataadr[1:0];

  assign hit   = (dataadr[31:4] == ADDR_BASE[31:4]);
  assign off   = dataadr[3:2];
  assign we    = memwrite & hit;
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : mem[rd_ptr];

  assign push = we && (off == OFF_TXDATA);
  assign pop  = tx_valid & tx_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);

  assign cnt8 = 8'(count);

  // FIFO storage carries no reset; tx_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      halt      <= 1'b0;
      halt_code <= '0;
      txcount   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        txcount <= txcount + 32'd1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Overflow set takes priority over a software clear.
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (we && (off == OFF_STATUS) && writedata[2])
        ovf <= 1'b0;
      if (we && (off == OFF_HALT) && !halt) begin
        halt      <= 1'b1;
        halt_code <= writedata;
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (hit) begin
      case (off)
        OFF_TXDATA:  readdata = '0;
        OFF_STATUS:  readdata = {16'b0, cnt8, 5'b0, ovf, full, empty};
        OFF_HALT:    readdata = halt_code;
        OFF_TXCOUNT: readdata = txcount;
        default:     readdata = '0;
      endcase
    end
  end

endmodule
